// File: rtl/mips_pkg.sv
// Shared MIPS-I decode constants: ALU operation codes, opcodes, instruction field slices.
// Latency: none (constants only).
// Backpressure: not applicable.
package mips_pkg;

    // ALU operation codes. R-type codes equal the funct field, so decode can pass funct through.
    localparam logic [5:0] ALU_SLL  = 6'b000000;
    localparam logic [5:0] ALU_SRL  = 6'b000010;
    localparam logic [5:0] ALU_SRA  = 6'b000011;
    localparam logic [5:0] ALU_SLLV = 6'b000100;
    localparam logic [5:0] ALU_SRLV = 6'b000110;
    localparam logic [5:0] ALU_SRAV = 6'b000111;
    localparam logic [5:0] ALU_LUI  = 6'b001111;
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_SUBU = 6'b100011;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_NOR  = 6'b100111;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_SLTU = 6'b101011;

    // Primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // Instruction field slices.
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

endpackage

// File: rtl/alu_op_issue_stage_if.sv
// Issue-stage bundle: upstream (instr + operands, flush) and downstream (ALU op + operands).
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// master: drives the stage inputs (register-read side and EX consumer); slave: the stage.
interface alu_op_issue_stage_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    operation;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic [4:0]    dest_reg;
    logic          reg_write;
    logic          illegal;

    modport master (
        output in_valid, instr, rs_data, rt_data, flush, out_ready,
        input  in_ready, out_valid, operation, data_a, data_b, dest_reg, reg_write, illegal
    );

    modport slave (
        input  in_valid, instr, rs_data, rt_data, flush, out_ready,
        output in_ready, out_valid, operation, data_a, data_b, dest_reg, reg_write, illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS-I decode into ALU operation, operands, destination and writeback enable.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage decides when the result is captured.
// Ports: instr/rs_data/rt_data in; nxt_operation, nxt_data_a, nxt_data_b, nxt_dest_reg,
//        nxt_reg_write, nxt_illegal out. ILLEGAL_TRAP_EN: flag unsupported encodings on nxt_illegal.
module alu_op_decode
    import mips_pkg::*;
#(
    parameter int          DW     = 32,
    parameter logic [5:0]  NOP_OP = 6'b100001
) (
    input  logic [31:0]   instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    output logic [5:0]    nxt_operation,
    output logic [DW-1:0] nxt_data_a,
    output logic [DW-1:0] nxt_data_b,
    output logic [4:0]    nxt_dest_reg,
    output logic          nxt_reg_write,
    output logic          nxt_illegal
);
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        supported;
    logic        unused_rs_field;

    assign opcode = instr[OP_MSB:OP_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm    = instr[IMM_MSB:IMM_LSB];
    // rs index is already resolved into rs_data by the register file.
    assign unused_rs_field = ^instr[RS_MSB:RS_LSB];

    always_comb begin
        nxt_operation = NOP_OP;
        nxt_data_a    = rs_data;
        nxt_data_b    = rt_data;
        nxt_dest_reg  = rd;
        supported     = 1'b0;
        if (opcode == OP_RTYPE) begin
            nxt_operation = funct;
            case (funct)
                ALU_SLL, ALU_SRL, ALU_SRA: begin
                    nxt_data_a = {{(DW-5){1'b0}}, shamt};
                    supported  = 1'b1;
                end
                // Variable shifts: only the low 5 bits of rs are a meaningful amount.
                ALU_SLLV, ALU_SRLV, ALU_SRAV: begin
                    nxt_data_a = {{(DW-5){1'b0}}, rs_data[4:0]};
                    supported  = 1'b1;
                end
                ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR,
                ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU: begin
                    supported = 1'b1;
                end
                default: supported = 1'b0;
            endcase
        end else begin
            nxt_dest_reg = rt;
            supported    = 1'b1;
            case (opcode)
                OP_ADDI:  begin nxt_operation = ALU_ADD;  nxt_data_b = {{(DW-16){imm[15]}}, imm}; end
                OP_ADDIU: begin nxt_operation = ALU_ADDU; nxt_data_b = {{(DW-16){imm[15]}}, imm}; end
                OP_SLTI:  begin nxt_operation = ALU_SLT;  nxt_data_b = {{(DW-16){imm[15]}}, imm}; end
                OP_SLTIU: begin nxt_operation = ALU_SLTU; nxt_data_b = {{(DW-16){imm[15]}}, imm}; end
                OP_ANDI:  begin nxt_operation = ALU_AND;  nxt_data_b = {{(DW-16){1'b0}}, imm}; end
                OP_ORI:   begin nxt_operation = ALU_OR;   nxt_data_b = {{(DW-16){1'b0}}, imm}; end
                OP_XORI:  begin nxt_operation = ALU_XOR;  nxt_data_b = {{(DW-16){1'b0}}, imm}; end
                OP_LUI:   begin nxt_operation = ALU_LUI;  nxt_data_b = {{(DW-16){1'b0}}, imm}; end
                default:  supported = 1'b0;
            endcase
        end
        // Unsupported encodings leave as a harmless ADDU 0,0 -> $0 with no writeback.
        if (!supported) begin
            nxt_operation = NOP_OP;
            nxt_data_a    = '0;
            nxt_data_b    = '0;
            nxt_dest_reg  = '0;
        end
    end

    assign nxt_reg_write = supported && (nxt_dest_reg != 5'd0);

`ifdef ILLEGAL_TRAP_EN
    assign nxt_illegal = !supported;
`else
    assign nxt_illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_op_issue_stage.sv
// ID->EX issue slot: decodes an instruction and holds ALU op, operands and writeback info.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold bit-stable while stalled.
// Ports: clk, rst_n (async active-low); bus (slave modport of alu_op_issue_stage_if).
// ILLEGAL_TRAP_EN (in alu_op_decode): unsupported encodings raise illegal instead of a silent bubble.
module alu_op_issue_stage
    import mips_pkg::*;
#(
    parameter int         DW     = 32,
    parameter logic [5:0] NOP_OP = 6'b100001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_op_issue_stage_if.slave   bus
);
    logic [5:0]    nxt_operation;
    logic [DW-1:0] nxt_data_a;
    logic [DW-1:0] nxt_data_b;
    logic [4:0]    nxt_dest_reg;
    logic          nxt_reg_write;
    logic          nxt_illegal;

    logic          out_valid_q;
    logic [5:0]    operation_q;
    logic [DW-1:0] data_a_q;
    logic [DW-1:0] data_b_q;
    logic [4:0]    dest_reg_q;
    logic          reg_write_q;
    logic          illegal_q;

    logic          capture;
    logic          consume;

    alu_op_decode #(
        .DW     (DW),
        .NOP_OP (NOP_OP)
    ) u_decode (
        .instr         (bus.instr),
        .rs_data       (bus.rs_data),
        .rt_data       (bus.rt_data),
        .nxt_operation (nxt_operation),
        .nxt_data_a    (nxt_data_a),
        .nxt_data_b    (nxt_data_b),
        .nxt_dest_reg  (nxt_dest_reg),
        .nxt_reg_write (nxt_reg_write),
        .nxt_illegal   (nxt_illegal)
    );

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;
    assign consume      = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            operation_q <= NOP_OP;
            data_a_q    <= '0;
            data_b_q    <= '0;
            dest_reg_q  <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (bus.flush) begin
            // Squash: kill side effects, leave the datapath fields as they were.
            out_valid_q <= 1'b0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            operation_q <= nxt_operation;
            data_a_q    <= nxt_data_a;
            data_b_q    <= nxt_data_b;
            dest_reg_q  <= nxt_dest_reg;
            reg_write_q <= nxt_reg_write;
            illegal_q   <= nxt_illegal;
        end else if (consume) begin
            // illegal describes the held slot, so it leaves with it.
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.operation = operation_q;
    assign bus.data_a    = data_a_q;
    assign bus.data_b    = data_b_q;
    assign bus.dest_reg  = dest_reg_q;
    assign bus.reg_write = reg_write_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_op_issue_stage.sv
// Directed bench for alu_op_issue_stage: decode vectors, stall, flush, illegal, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge after capture.
// Define ILLEGAL_TRAP_EN for both bench and RTL to exercise the trap build.
module tb_alu_op_issue_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_op_issue_stage_if #(.DW(32)) bus ();

    alu_op_issue_stage #(
        .DW     (32),
        .NOP_OP (6'b100001)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one instruction for a single cycle, then sample after the capturing edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.instr     = ins;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.rs_data   = '0;
        bus.rt_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_operation", 32'(bus.operation), 32'h21);
        check("rst_reg_write", 32'(bus.reg_write), 32'd0);
        check("rst_data_a",    bus.data_a,         32'd0);
        check("rst_illegal",   32'(bus.illegal),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // addu $3,$1,$2
        issue(32'h00221821, 32'd5, 32'd7);
        check("addu_valid", 32'(bus.out_valid), 32'd1);
        check("addu_op",    32'(bus.operation), 32'h21);
        check("addu_a",     bus.data_a,         32'd5);
        check("addu_b",     bus.data_b,         32'd7);
        check("addu_dest",  32'(bus.dest_reg),  32'd3);
        check("addu_wr",    32'(bus.reg_write), 32'd1);

        // sra $4,$2,3 : shamt replaces rs
        issue(32'h000220C3, 32'hDEADBEEF, 32'h80000000);
        check("sra_op",   32'(bus.operation), 32'h03);
        check("sra_a",    bus.data_a,         32'd3);
        check("sra_b",    bus.data_b,         32'h80000000);
        check("sra_dest", 32'(bus.dest_reg),  32'd4);

        // sllv $4,$2,$1 : shift amount masked to rs[4:0]
        issue(32'h00222004, 32'h00000025, 32'h00000011);
        check("sllv_op", 32'(bus.operation), 32'h04);
        check("sllv_a",  bus.data_a,         32'd5);

        // addi $6,$1,-1
        issue(32'h2026FFFF, 32'd100, 32'd9);
        check("addi_op",   32'(bus.operation), 32'h20);
        check("addi_a",    bus.data_a,         32'd100);
        check("addi_b",    bus.data_b,         32'hFFFFFFFF);
        check("addi_dest", 32'(bus.dest_reg),  32'd6);

        // ori $7,$1,0xFFFF
        issue(32'h3427FFFF, 32'd1, 32'd9);
        check("ori_op", 32'(bus.operation), 32'h25);
        check("ori_b",  bus.data_b,         32'h0000FFFF);

        // lui $5,0x1234
        issue(32'h3C051234, 32'd0, 32'd9);
        check("lui_op",   32'(bus.operation), 32'h0F);
        check("lui_b",    bus.data_b,         32'h00001234);
        check("lui_dest", 32'(bus.dest_reg),  32'd5);
        check("lui_wr",   32'(bus.reg_write), 32'd1);

        // All-zero NOP: sll $0,$0,0 issues without writeback
        issue(32'h00000000, 32'd3, 32'd4);
        check("nop_valid", 32'(bus.out_valid), 32'd1);
        check("nop_wr",    32'(bus.reg_write), 32'd0);

        // Unsupported funct 000001
        issue(32'h00221801, 32'd5, 32'd7);
        check("badfn_op", 32'(bus.operation), 32'h21);
        check("badfn_wr", 32'(bus.reg_write), 32'd0);

        // Stall: hold addu while a lui waits upstream
        issue(32'h00221821, 32'd5, 32'd7);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h3C051234;
        bus.rs_data   = 32'd0;
        bus.rt_data   = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready),  32'd0);
            check("stall_valid",    32'(bus.out_valid), 32'd1);
            check("stall_op",       32'(bus.operation), 32'h21);
            check("stall_a",        bus.data_a,         32'd5);
            check("stall_b",        bus.data_b,         32'd7);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("unstall_op", 32'(bus.operation), 32'h0F);
        check("unstall_b",  bus.data_b,         32'h00001234);

        // Consume with nothing new: valid drops, data holds
        @(negedge clk);
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_b",     bus.data_b,         32'h00001234);

        // Flush with a stalled slot and an incoming ori
        issue(32'h00221821, 32'd5, 32'd7);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b1;
        bus.instr     = 32'h3427FFFF;
        bus.rs_data   = 32'd1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_wr",    32'(bus.reg_write), 32'd0);
        check("flush_b",     bus.data_b,         32'd7);
        @(negedge clk);
        check("flush_drop", 32'(bus.out_valid), 32'd0);

        // Unsupported opcode 111111
        issue(32'hFC000000, 32'd1, 32'd2);
        check("ill_valid", 32'(bus.out_valid), 32'd1);
        check("ill_wr",    32'(bus.reg_write), 32'd0);
        check("ill_op",    32'(bus.operation), 32'h21);
`ifdef ILLEGAL_TRAP_EN
        check("ill_flag", 32'(bus.illegal), 32'd1);
`else
        check("ill_flag", 32'(bus.illegal), 32'd0);
`endif

        // Asynchronous reset mid-stream
        issue(32'h00221821, 32'd5, 32'd7);
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_op",    32'(bus.operation), 32'h21);
        check("arst_wr",    32'(bus.reg_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
